// File: rtl/wb_arbiter4_if.sv
// Wishbone pipelined bus bundle: dat_w flows master->slave, dat_r slave->master.
interface if_wb;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;
    logic        stall;

    modport master (output cyc, stb, we, adr, sel, dat_w, input dat_r, ack, stall);
    modport slave  (input cyc, stb, we, adr, sel, dat_w, output dat_r, ack, stall);
endinterface

// File: rtl/wb_arbiter4.sv
// Four-master round-robin Wishbone pipelined arbiter with outstanding tracking
// and a bus watchdog that drains hung transfers with a fixed data word.
module wb_arbiter4_port #(
    parameter logic [31:0] TOUT_DATA = 32'hffffffff
) (
    input  logic        routed,
    input  logic        draining,
    input  logic        bus_ack,
    input  logic        bus_stall,
    input  logic        full,
    input  logic [31:0] bus_dat,
    output logic        ack,
    output logic        stall,
    output logic [31:0] dat
);
    always_comb begin
        ack   = 1'b0;
        stall = 1'b1;
        dat   = '0;
        if (routed) begin
            ack   = bus_ack;
            stall = bus_stall | full;
            dat   = bus_dat;
        end else if (draining) begin
            ack = 1'b1;
            dat = TOUT_DATA;
        end
    end
endmodule

module wb_arbiter4 #(
    parameter int          TIMEOUT   = 256,
    parameter int          OUT_W     = 4,
    parameter logic [31:0] TOUT_DATA = 32'hffffffff
) (
    input  logic       clk_i,
    input  logic       rst_i,
    if_wb.slave        m0,
    if_wb.slave        m1,
    if_wb.slave        m2,
    if_wb.slave        m3,
    if_wb.master       sbus,
    output logic [1:0] gnt_o,
    output logic       busy_o,
    output logic       tout_o
);
    localparam int NUM_M = 4;
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, TOUT} state_t;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
    } wb_req_t;

    state_t                       state_q;
    logic [1:0]                   gnt_q;
    logic [1:0]                   last_q;
    logic [OUT_W-1:0]             outs_q;
    logic [WD_W-1:0]              wd_q;

    wb_req_t [NUM_M-1:0]          req;
    wb_req_t                      cur;
    logic [NUM_M-1:0]             m_cyc;
    logic [NUM_M-1:0]             m_ack;
    logic [NUM_M-1:0]             m_stall;
    logic [NUM_M-1:0][31:0]       m_dat;
    logic [NUM_M-1:0]             routed;
    logic [NUM_M-1:0]             draining;

    logic [1:0]                   winner;
    logic [1:0]                   idx;
    logic                         full;
    logic                         stb_o;
    logic                         accept;
    logic                         dec;
    logic                         wd_fire;
    logic [OUT_W-1:0]             outs_bus;

    assign req[0] = {m0.cyc, m0.stb, m0.we, m0.adr, m0.sel, m0.dat_w};
    assign req[1] = {m1.cyc, m1.stb, m1.we, m1.adr, m1.sel, m1.dat_w};
    assign req[2] = {m2.cyc, m2.stb, m2.we, m2.adr, m2.sel, m2.dat_w};
    assign req[3] = {m3.cyc, m3.stb, m3.we, m3.adr, m3.sel, m3.dat_w};

    assign m0.ack = m_ack[0];  assign m0.stall = m_stall[0];  assign m0.dat_r = m_dat[0];
    assign m1.ack = m_ack[1];  assign m1.stall = m_stall[1];  assign m1.dat_r = m_dat[1];
    assign m2.ack = m_ack[2];  assign m2.stall = m_stall[2];  assign m2.dat_r = m_dat[2];
    assign m3.ack = m_ack[3];  assign m3.stall = m_stall[3];  assign m3.dat_r = m_dat[3];

    assign cur = req[gnt_q];

    // An ack landing this cycle frees a slot, so a full pipe can still accept.
    assign full   = (outs_q == {OUT_W{1'b1}}) && !sbus.ack;
    assign stb_o  = (state_q == BUSY) && cur.cyc && cur.stb && !full;
    assign accept = stb_o && !sbus.stall;
    assign dec    = sbus.ack && (outs_q != '0);

    assign sbus.cyc   = (state_q == BUSY) && cur.cyc;
    assign sbus.stb   = stb_o;
    assign sbus.we    = cur.we;
    assign sbus.adr   = cur.adr;
    assign sbus.sel   = cur.sel;
    assign sbus.dat_w = cur.dat;

    assign wd_fire = (TIMEOUT != 0) && (state_q == BUSY) && cur.cyc &&
                     (wd_q == WD_W'(TIMEOUT));

    assign tout_o = wd_fire;
    assign busy_o = (state_q != IDLE);
    assign gnt_o  = gnt_q;

    always_comb begin
        outs_bus = outs_q;
        if (accept && !dec)
            outs_bus = outs_q + 1'b1;
        else if (dec && !accept)
            outs_bus = outs_q - 1'b1;
    end

    // Descending scan so the nearest requester after last_q wins.
    always_comb begin
        winner = last_q;
        idx    = last_q;
        for (int i = NUM_M; i >= 1; i--) begin
            idx = last_q + 2'(i);
            if (m_cyc[idx])
                winner = idx;
        end
    end

    generate
        for (genvar i = 0; i < NUM_M; i++) begin : g_port
            assign m_cyc[i]    = req[i].cyc;
            assign routed[i]   = (state_q == BUSY) && (gnt_q == 2'(i));
            assign draining[i] = (state_q == TOUT) && (gnt_q == 2'(i)) &&
                                 cur.cyc && (outs_q != '0);

            wb_arbiter4_port #(.TOUT_DATA(TOUT_DATA)) u_port (
                .routed    (routed[i]),
                .draining  (draining[i]),
                .bus_ack   (sbus.ack),
                .bus_stall (sbus.stall),
                .full      (full),
                .bus_dat   (sbus.dat_r),
                .ack       (m_ack[i]),
                .stall     (m_stall[i]),
                .dat       (m_dat[i])
            );
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= 2'd3;
            outs_q  <= '0;
            wd_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|m_cyc) begin
                        state_q <= BUSY;
                        gnt_q   <= winner;
                    end
                end
                BUSY: begin
                    if (!cur.cyc) begin
                        state_q <= IDLE;
                        last_q  <= gnt_q;
                        outs_q  <= '0;
                        wd_q    <= '0;
                    end else begin
                        outs_q <= outs_bus;
                        if (wd_fire) begin
                            state_q <= TOUT;
                            wd_q    <= '0;
                        end else if (sbus.ack || (outs_q == '0) || (TIMEOUT == 0)) begin
                            wd_q <= '0;
                        end else begin
                            wd_q <= wd_q + 1'b1;
                        end
                    end
                end
                TOUT: begin
                    if (!cur.cyc) begin
                        state_q <= IDLE;
                        last_q  <= gnt_q;
                        outs_q  <= '0;
                    end else if (outs_q != '0) begin
                        outs_q <= outs_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/wb_arbiter4.md
Name: wb_arbiter4

Overview:
- Four-master round-robin Wishbone pipelined arbiter; its single master port drives the slave port of the address decoder (mmu) upstream of all peripherals.
- Arbitration is per bus cycle: a grant is held for as long as the granted master holds cyc.
- Tracks outstanding requests so that an ack always returns to the requester.
- A bus watchdog completes hung transfers with a fixed data word and a flag pulse.

Parameters:
- TIMEOUT, 256, cycles without an ack while requests are outstanding before the watchdog fires; 0 disables the watchdog.
- OUT_W, 4, width of the outstanding-request counter; the maximum number in flight is 2^OUT_W-1.
- TOUT_DATA, 32'hffffffff, dat returned to the master on each watchdog-generated ack.

Ports:
- clk_i  input  1  clock; all state is updated on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- m0  if_wb.slave  interface (32b adr/dat, 4b sel)  master 0 request port.
- m1  if_wb.slave  interface  master 1 request port.
- m2  if_wb.slave  interface  master 2 request port.
- m3  if_wb.slave  interface  master 3 request port.
- sbus  if_wb.master  interface  arbitrated bus toward the decoder.
- gnt_o  output  2  index of the currently granted master; valid when busy_o=1.
- busy_o  output  1  high in BUSY and TOUT states.
- tout_o  output  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset (rst_i=0, asynchronous) sets:
  - state=IDLE, last=3 (so master 0 has first priority), outstanding=0, watchdog count=0.
  - sbus.cyc=0, sbus.stb=0.
  - all mN.ack=0, all mN.stall=1, all mN dat_o=0.
  - tout_o=0, busy_o=0, gnt_o=0.
- States: IDLE, BUSY, TOUT.
- IDLE:
  - sbus.cyc=0; every master sees stall=1 and ack=0.
  - If any mN.cyc=1, grant the first requester scanning last+1, last+2, ... modulo 4.
  - The grant is registered: next cycle state=BUSY, gnt_o=winner. sbus.cyc therefore rises one cycle after the master's cyc (one-cycle arbitration latency).
- BUSY, routing:
  - sbus.cyc = m[gnt].cyc.
  - adr, we, sel and dat pass combinationally from m[gnt] to sbus.
  - sbus.stb = m[gnt].stb & !full.
  - m[gnt].stall = sbus.stall | full.
  - m[gnt].ack = sbus.ack; m[gnt] dat_o = sbus dat.
  - Non-granted masters: stall=1, ack=0, dat_o=0.
- BUSY, outstanding counter:
  - +1 when sbus.stb & !sbus.stall; -1 when sbus.ack.
  - Both in the same cycle: count unchanged.
  - full = (count == 2^OUT_W-1).
  - An ack arriving with count=0 is still forwarded and the count stays 0 (no underflow).
- BUSY, release:
  - When m[gnt].cyc=0, the next state is IDLE, last=gnt, and outstanding and watchdog are cleared (Wishbone abort is legal).
  - The cyc drop passes straight through to sbus.cyc in the same cycle.
- Watchdog counting (BUSY only):
  - Increments each cycle with outstanding>0 and sbus.ack=0.
  - Cleared on any ack or when outstanding=0.
- Watchdog firing:
  - When the count reaches TIMEOUT (TIMEOUT≠0), the watchdog fires.
  - tout_o=1 for that one cycle and the next state is TOUT.
- TOUT:
  - sbus.cyc=0 and sbus.stb=0 (aborts the slave); m[gnt].stall=1.
  - Each cycle while outstanding>0: m[gnt].ack=1, dat_o=TOUT_DATA, outstanding-1.
  - After the drain, acks stop and the block waits for m[gnt].cyc=0, then goes to IDLE with last=gnt.
  - If the master drops cyc mid-drain, go to IDLE immediately and clear outstanding.
- Fairness: a master that was just released has lowest priority at the next arbitration. With all four requesting, the grant order is 0,1,2,3,0.
- Reset asserted mid-cycle:
  - Immediate return to the reset values.
  - sbus.cyc drops asynchronously; in-flight requests are discarded with no acks.

Test Plan:
- Single read: m1 cyc/stb with adr=32'h2000_0010, we=0. Required: sbus.cyc rises one cycle later; the slave acks with dat=32'h1234_5678; m1 sees ack with 32'h1234_5678; gnt_o=1; after m1 drops cyc, state=IDLE and last=1.
- Round robin: m0..m3 all assert cyc after reset, each doing one write then dropping cyc. Required: grant order 0,1,2,3; each sbus.cyc window is separated by one idle cycle; non-granted masters see stall=1 throughout.
- Pipelining/full with OUT_W=2: m2 issues 5 back-to-back stbs while the slave withholds ack. Required: sbus accepts 3 (count=3), m2 stall=1 on the 4th; release one ack, then the 4th is accepted in the same cycle (count stays 3).
- Watchdog with TIMEOUT=8: m0 has 2 accepted requests and no acks. Required: tout_o pulses 8 cycles after the last accept; sbus.cyc=0 next cycle; m0 gets 2 consecutive acks with dat=32'hffffffff; then stall=1 until m0 drops cyc.
- Abort: m3 has 2 outstanding and drops cyc. Required: sbus.cyc=0 in the same cycle, state=IDLE next cycle, count=0; a later m0 request is granted normally.
- Async reset: assert rst_i=0 between clock edges while BUSY. Required: sbus.cyc=0 and all stalls=1 before the next edge; after release, master 0 has highest priority.
